operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 15 +
 rtl/operand_fetch.sv | 124 ++++++++++++
 tb/tb_operand_fetch.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared core definitions for the operand fetch stage: widths and FSM encoding.
package operand_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TAG_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/operand_fetch.sv
// Operand fetch: arbitrates writeback vs decode onto a registered-read register bank,
// captures both source operands and holds them, with writeback forwarding while held.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs,
  input  logic [ADDR_W-1:0] dec_rt,
  input  logic [TAG_W-1:0]  dec_tag,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_address,
  output logic [ADDR_W-1:0] rf_addressB,
  output logic              rf_enable_write,
  output logic              rf_enable_read,
  output logic [DATA_W-1:0] rf_in_data,
  output logic [DATA_W-1:0] rf_in_dataB,
  input  logic [DATA_W-1:0] rf_out_data,
  input  logic [DATA_W-1:0] rf_out_dataB,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [TAG_W-1:0]  op_tag
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] rs_p0, rt_p0;
  logic [TAG_W-1:0]  tag_p0;
  logic              wb_acc, wb_wr, dec_acc, fwd_a, fwd_b;

  // Register 0 reads as zero regardless of what the bank returns.
  function automatic logic [DATA_W-1:0] zero_if_r0(input logic [ADDR_W-1:0] idx,
                                                   input logic [DATA_W-1:0] val);
    return (idx == '0) ? '0 : val;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dec_acc) state_nxt = READ;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (op_ready) state_nxt = IDLE;
    endcase
  end

  // wb_ready stays low in READ/CAPTURE so the bank read is never disturbed by a write.
  always_comb begin
    dec_ready      = 1'b0;
    wb_ready       = 1'b0;
    rf_enable_read = 1'b0;
    op_valid       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          dec_ready = !wb_valid;
          wb_ready  = 1'b1;
        end
        READ:    rf_enable_read = 1'b1;
        CAPTURE: ;
        HOLD: begin
          wb_ready = 1'b1;
          op_valid = 1'b1;
        end
      endcase
    end
  end

  assign wb_acc          = wb_valid & wb_ready;
  assign wb_wr           = wb_acc & (wb_addr != '0);
  assign dec_acc         = dec_valid & dec_ready;
  assign rf_enable_write = wb_wr;
  assign rf_address      = wb_wr ? wb_addr : rs_p0;
  assign rf_addressB     = wb_wr ? wb_addr : rt_p0;
  assign rf_in_data      = wb_data;
  assign rf_in_dataB     = wb_data;
  assign fwd_a           = wb_wr && (state == HOLD) && (wb_addr == rs_p0);
  assign fwd_b           = wb_wr && (state == HOLD) && (wb_addr == rt_p0);

  // Stage p0: decode fields latched on accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_p0  <= '0;
      rt_p0  <= '0;
      tag_p0 <= '0;
    end else if (dec_acc) begin
      rs_p0  <= dec_rs;
      rt_p0  <= dec_rt;
      tag_p0 <= dec_tag;
    end
  end

  // Operand stage: capture bank read data, then forward matching writebacks while held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      op_tag <= '0;
    end else if (state == CAPTURE) begin
      op_a   <= zero_if_r0(rs_p0, rf_out_data);
      op_b   <= zero_if_r0(rt_p0, rf_out_dataB);
      op_tag <= tag_p0;
    end else begin
      if (fwd_a) op_a <= wb_data;
      if (fwd_b) op_b <= wb_data;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized transactions
// checked against an architectural register-file model with hold-time forwarding.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          dec_valid = 1'b0, dec_ready;
  logic [AW-1:0] dec_rs = '0, dec_rt = '0;
  logic [TW-1:0] dec_tag = '0;
  logic          wb_valid = 1'b0, wb_ready;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic [AW-1:0] rf_address, rf_addressB;
  logic          rf_enable_write, rf_enable_read;
  logic [DW-1:0] rf_in_data, rf_in_dataB;
  logic [DW-1:0] bank_out_a = '0, bank_out_b = '0;
  logic          op_valid, op_ready = 1'b0;
  logic [DW-1:0] op_a, op_b;
  logic [TW-1:0] op_tag;

  always #5 clock = ~clock;

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_tag(dec_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_address(rf_address), .rf_addressB(rf_addressB),
    .rf_enable_write(rf_enable_write), .rf_enable_read(rf_enable_read),
    .rf_in_data(rf_in_data), .rf_in_dataB(rf_in_dataB),
    .rf_out_data(bank_out_a), .rf_out_dataB(bank_out_b),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag)
  );

  // Registered-read register bank; entry 0 is not hardwired, so masking must come from the DUT.
  logic [DW-1:0] bank [32];
  always @(posedge clock) begin
    if (rf_enable_write) bank[rf_address] <= rf_in_data;
    if (rf_enable_read) begin
      bank_out_a <= bank[rf_address];
      bank_out_b <= bank[rf_addressB];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] ref_rf [32];
  logic [DW-1:0] exp_a, exp_b;
  logic [TW-1:0] exp_tag;
  logic [AW-1:0] cur_rs, cur_rt;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  always @(negedge clock)
    if (!reset) check1("strobe_excl", rf_enable_read & rf_enable_write, 1'b0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Architectural effect of an accepted writeback; in HOLD it also overrides held operands.
  task automatic apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit in_hold);
    if (a != '0) begin
      ref_rf[a] = d;
      if (in_hold && a == cur_rs) exp_a = d;
      if (in_hold && a == cur_rt) exp_b = d;
    end
  endtask

  // All tasks start and end at the drive point (1 time unit after a rising edge).
  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit in_hold);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clock);
    check1("wb_ready", wb_ready, 1'b1);
    check1("wr_strobe", rf_enable_write, a != '0);
    if (a != '0) begin
      check("wr_addr", 32'(rf_address), 32'(a));
      check("wr_addrB", 32'(rf_addressB), 32'(a));
      check("wr_data", rf_in_data, d);
      check("wr_dataB", rf_in_dataB, d);
    end
    @(posedge clock); #1;
    apply_write(a, d, in_hold);
    wb_valid = 1'b0;
  endtask

  task automatic decode(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [TW-1:0] tag,
                        input bit hold_rdy, input bit wb_hold,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int n;
    dec_valid = 1'b1; dec_rs = rs; dec_rt = rt; dec_tag = tag;
    n = 0;
    @(negedge clock);
    while (!dec_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check1("dec_ready", dec_ready, 1'b1);
    @(posedge clock); #1;
    dec_valid = 1'b0;
    op_ready  = hold_rdy;
    if (wb_hold) begin
      wb_valid = 1'b1; wb_addr = wa; wb_data = wd;
    end
    cur_rs  = rs;
    cur_rt  = rt;
    exp_a   = (rs == '0) ? '0 : ref_rf[rs];
    exp_b   = (rt == '0) ? '0 : ref_rf[rt];
    exp_tag = tag;
    n = 1;
    @(negedge clock);
    while (!op_valid && n < 10) begin
      check1("busy_wb_ready", wb_ready, 1'b0);
      check1("busy_wr", rf_enable_write, 1'b0);
      check1("busy_dec_ready", dec_ready, 1'b0);
      check1("rd_strobe", rf_enable_read, n == 1);
      if (n == 1) begin
        check("rd_addr", 32'(rf_address), 32'(rs));
        check("rd_addrB", 32'(rf_addressB), 32'(rt));
      end
      @(negedge clock);
      n++;
    end
    check("latency", 32'(n), 32'd3);
    check("op_a", op_a, exp_a);
    check("op_b", op_b, exp_b);
    check("op_tag", 32'(op_tag), 32'(exp_tag));
    if (wb_hold) begin
      check1("hold_wb_ready", wb_ready, 1'b1);
      check1("hold_wr", rf_enable_write, wa != '0);
      check1("hold_rd", rf_enable_read, 1'b0);
    end
    @(posedge clock); #1;
    if (wb_hold) apply_write(wa, wd, 1'b1);
    wb_valid = 1'b0;
    op_ready = 1'b0;
  endtask

  task automatic stall(input int cycles);
    repeat (cycles) begin
      @(negedge clock);
      check1("stall_valid", op_valid, 1'b1);
      check("stall_a", op_a, exp_a);
      check("stall_b", op_b, exp_b);
      check("stall_tag", 32'(op_tag), 32'(exp_tag));
      @(posedge clock); #1;
    end
  endtask

  task automatic release_op();
    op_ready = 1'b1;
    @(negedge clock);
    check1("rel_valid", op_valid, 1'b1);
    check("rel_a", op_a, exp_a);
    check("rel_b", op_b, exp_b);
    @(posedge clock); #1;
    op_ready = 1'b0;
    @(negedge clock);
    check1("rel_drop", op_valid, 1'b0);
    check1("rel_idle", dec_ready, 1'b1);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [AW-1:0] rs, rt, wa;
    logic [DW-1:0] d;
    bit            rdy, wbh;
    int            nw;

    for (int i = 0; i < 32; i++) begin
      bank[i]   = '0;
      ref_rf[i] = '0;
    end
    bank[0] = 32'hA5A5_A5A5;

    // Reset state
    @(negedge clock);
    check1("rst_dec_ready", dec_ready, 1'b0);
    check1("rst_wb_ready", wb_ready, 1'b0);
    check1("rst_op_valid", op_valid, 1'b0);
    check1("rst_we", rf_enable_write, 1'b0);
    check1("rst_re", rf_enable_read, 1'b0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_tag", 32'(op_tag), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check1("first_dec_ready", dec_ready, 1'b1);
    @(posedge clock); #1;

    // Basic writeback then fetch
    write(5'd5, 32'hDEAD_BEEF, 1'b0);
    decode(5'd5, 5'd0, 8'h11, 1'b0, 1'b0, '0, '0);
    release_op();

    // Writeback and decode together: writeback wins, decode goes next cycle
    d = $urandom;
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = d;
    dec_valid = 1'b1; dec_rs = 5'd2; dec_rt = 5'd5; dec_tag = 8'h42;
    @(negedge clock);
    check1("prio_dec_ready", dec_ready, 1'b0);
    check1("prio_wb_ready", wb_ready, 1'b1);
    check1("prio_we", rf_enable_write, 1'b1);
    @(posedge clock); #1;
    apply_write(5'd2, d, 1'b0);
    wb_valid = 1'b0;
    decode(5'd2, 5'd5, 8'h42, 1'b0, 1'b0, '0, '0);
    release_op();

    // Long hold, then forwarding writeback to rs
    write(5'd3, 32'h0BAD_F00D, 1'b0);
    decode(5'd7, 5'd3, 8'h77, 1'b0, 1'b0, '0, '0);
    stall(4);
    write(5'd7, 32'h1234_5678, 1'b1);
    stall(1);
    check("fwd_op_a", op_a, 32'h1234_5678);
    check("fwd_op_b", op_b, 32'h0BAD_F00D);
    check("fwd_bank_r7", bank[7], 32'h1234_5678);
    release_op();

    // Writeback pending through READ/CAPTURE, accepted in HOLD alongside op_ready
    d = 32'hCAFE_0044;
    decode(5'd3, 5'd9, 8'h44, 1'b1, 1'b1, 5'd9, d);
    check("rdyfwd_op_b", op_b, d);
    check1("rdyfwd_valid", op_valid, 1'b0);
    check("rdyfwd_bank_r9", bank[9], d);

    // Writes to r0 are accepted but never reach the bank; rs=0 reads as zero
    write(5'd0, 32'hFFFF_FFFF, 1'b0);
    decode(5'd0, 5'd5, 8'h45, 1'b0, 1'b0, '0, '0);
    check("r0_op_a", op_a, 32'd0);
    release_op();

    // Reset in CAPTURE with a writeback waiting
    dec_valid = 1'b1; dec_rs = 5'd5; dec_rt = 5'd5; dec_tag = 8'h66;
    @(negedge clock);
    check1("rc_dec_ready", dec_ready, 1'b1);
    @(posedge clock); #1;
    dec_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0BAD;
    @(posedge clock); #1;
    #2 reset = 1'b1;
    #1;
    check1("rc_op_valid", op_valid, 1'b0);
    check1("rc_we", rf_enable_write, 1'b0);
    check1("rc_re", rf_enable_read, 1'b0);
    check1("rc_wb_ready", wb_ready, 1'b0);
    check1("rc_dec_ready0", dec_ready, 1'b0);
    @(negedge clock);
    check("rc_op_a", op_a, 32'd0);
    check("rc_op_tag", 32'(op_tag), 32'd0);
    @(posedge clock); #1;
    wb_valid = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check1("rc_after_valid", op_valid, 1'b0);
      check1("rc_after_ready", dec_ready, 1'b1);
      @(posedge clock); #1;
    end
    check("rc_bank_r5", bank[5], ref_rf[5]);

    // Randomized traffic against the architectural model
    for (int i = 0; i < 25; i++) begin
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++) write(AW'($urandom_range(0, 31)), $urandom, 1'b0);
      rs  = AW'($urandom_range(0, 31));
      rt  = AW'($urandom_range(0, 31));
      rdy = 1'($urandom_range(0, 1));
      wbh = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       wa = rs;
        1:       wa = rt;
        default: wa = AW'($urandom_range(0, 31));
      endcase
      decode(rs, rt, TW'($urandom), rdy, wbh, wa, $urandom);
      if (!rdy) begin
        stall(int'($urandom_range(0, 2)));
        if ($urandom_range(0, 1) == 1) write(($urandom_range(0, 1) == 1) ? rs : rt, $urandom, 1'b1);
        release_op();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
